addsub_arbiter: RTL and testbench

Shares one 4-bit add/subtract datapath between two requesters. Each requester presents operands and a mode over a valid/ready handshake. The block arbitrates (round-robin or fixed priority), runs the operation through a single adder/subtractor slice and registers the result with both overflow flags. The result is then returned to the winning requester over a second valid/ready handshake. It sits between the control units that need arithmetic and the shared adder/subtractor, so only one adder is instantiated.

---
 rtl/addsub_arbiter_pkg.sv | 14 +
 rtl/addsub_rr_pick.sv | 20 ++
 rtl/addsub_arbiter.sv | 131 +++++++++++++
 tb/tb_addsub_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_arbiter_pkg.sv
// Shared types and constants for the two-requester add/subtract arbiter.
package addsub_arbiter_pkg;

  localparam int unsigned WidthDefault = 4;

  typedef logic req_idx_t;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } state_e;

endpackage

// File: rtl/addsub_rr_pick.sv
// Combinational two-requester picker: round-robin against 'last', or fixed priority to 0.
module addsub_rr_pick
  import addsub_arbiter_pkg::*;
(
  input  logic [1:0] valid,
  input  req_idx_t   last,
  input  logic       fixed_prio,
  output req_idx_t   winner
);

  always_comb begin
    winner = 1'b0;
    unique case (valid)
      2'b10:   winner = 1'b1;
      2'b11:   winner = fixed_prio ? 1'b0 : ~last;
      default: winner = 1'b0;
    endcase
  end

endmodule

// File: rtl/addsub_arbiter.sv
// Arbitrates two requesters onto one add/subtract slice; result is returned over
// a per-requester valid/ready handshake.
module addsub_arbiter
  import addsub_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH      = WidthDefault,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [1:0]       REQ_VALID,
  output logic [1:0]       REQ_READY,
  input  logic [WIDTH-1:0] X0,
  input  logic [WIDTH-1:0] Y0,
  input  logic             MODE0,
  input  logic [WIDTH-1:0] X1,
  input  logic [WIDTH-1:0] Y1,
  input  logic             MODE1,
  output logic [1:0]       RES_VALID,
  input  logic [1:0]       RES_READY,
  output logic [WIDTH-1:0] S,
  output logic             OVU,
  output logic             OVS,
  output logic             BUSY,
  output logic             GRANT_ID
);

  state_e           state_q, state_d;
  req_idx_t         last_q, last_d;
  req_idx_t         grant_q, grant_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             ovu_q, ovu_d, ovs_q, ovs_d;
  logic [1:0]       res_valid_q, res_valid_d;
  req_idx_t         winner;

  addsub_rr_pick u_pick (
    .valid      (REQ_VALID),
    .last       (last_q),
    .fixed_prio (FIXED_PRIO),
    .winner     (winner)
  );

  // Full sum gives carry out of the MSB; the sum of the low bits exposes the carry into it.
  logic [WIDTH-1:0] y_eff;
  logic [WIDTH:0]   sum_full;
  logic [WIDTH-1:0] sum_low;

  always_comb begin
    y_eff    = y_q ^ {WIDTH{mode_q}};
    sum_full = {1'b0, x_q} + {1'b0, y_eff} + {{WIDTH{1'b0}}, mode_q};
    sum_low  = {1'b0, x_q[WIDTH-2:0]} + {1'b0, y_eff[WIDTH-2:0]} + {{(WIDTH-1){1'b0}}, mode_q};
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    grant_d     = grant_q;
    x_d         = x_q;
    y_d         = y_q;
    mode_d      = mode_q;
    s_d         = s_q;
    ovu_d       = ovu_q;
    ovs_d       = ovs_q;
    res_valid_d = res_valid_q;
    REQ_READY   = 2'b00;
    unique case (state_q)
      StIdle: begin
        if (|REQ_VALID && !RST) begin
          REQ_READY[winner] = 1'b1;
          grant_d           = winner;
          x_d               = winner ? X1 : X0;
          y_d               = winner ? Y1 : Y0;
          mode_d            = winner ? MODE1 : MODE0;
          state_d           = StExec;
        end
      end
      StExec: begin
        s_d                  = sum_full[WIDTH-1:0];
        ovu_d                = sum_full[WIDTH];
        ovs_d                = sum_full[WIDTH] ^ sum_low[WIDTH-1];
        res_valid_d          = 2'b00;
        res_valid_d[grant_q] = 1'b1;
        state_d              = StResp;
      end
      StResp: begin
        if (RES_READY[grant_q]) begin
          last_d      = grant_q;
          res_valid_d = 2'b00;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= StIdle;
      last_q      <= 1'b1;
      grant_q     <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      mode_q      <= 1'b0;
      s_q         <= '0;
      ovu_q       <= 1'b0;
      ovs_q       <= 1'b0;
      res_valid_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      x_q         <= x_d;
      y_q         <= y_d;
      mode_q      <= mode_d;
      s_q         <= s_d;
      ovu_q       <= ovu_d;
      ovs_q       <= ovs_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign RES_VALID = res_valid_q;
  assign S         = s_q;
  assign OVU       = ovu_q;
  assign OVS       = ovs_q;
  assign BUSY      = (state_q != StIdle);
  assign GRANT_ID  = grant_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed self-checking bench for addsub_arbiter (round-robin and fixed-priority instances).
module tb_addsub_arbiter;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [1:0] req_valid = 2'b00, res_ready = 2'b00;
  logic [3:0] x0 = 4'd0, y0 = 4'd0, x1 = 4'd0, y1 = 4'd0;
  logic       mode0 = 1'b0, mode1 = 1'b0;
  logic [1:0] REQ_READY, RES_VALID;
  logic [3:0] S;
  logic       OVU, OVS, BUSY, GRANT_ID;

  logic [1:0] f_req_valid = 2'b00, f_res_ready = 2'b00;
  logic [1:0] f_req_ready, f_res_valid;
  logic [3:0] f_s;
  logic       f_ovu, f_ovs, f_busy, f_grant;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  addsub_arbiter #(.WIDTH(4), .FIXED_PRIO(1'b0)) dut (
    .CLK(CLK), .RST(RST), .REQ_VALID(req_valid), .REQ_READY(REQ_READY),
    .X0(x0), .Y0(y0), .MODE0(mode0), .X1(x1), .Y1(y1), .MODE1(mode1),
    .RES_VALID(RES_VALID), .RES_READY(res_ready), .S(S), .OVU(OVU), .OVS(OVS),
    .BUSY(BUSY), .GRANT_ID(GRANT_ID)
  );

  addsub_arbiter #(.WIDTH(4), .FIXED_PRIO(1'b1)) dut_fp (
    .CLK(CLK), .RST(RST), .REQ_VALID(f_req_valid), .REQ_READY(f_req_ready),
    .X0(4'd1), .Y0(4'd1), .MODE0(1'b0), .X1(4'd2), .Y1(4'd1), .MODE1(1'b0),
    .RES_VALID(f_res_valid), .RES_READY(f_res_ready), .S(f_s), .OVU(f_ovu), .OVS(f_ovs),
    .BUSY(f_busy), .GRANT_ID(f_grant)
  );

  // Drives one operation through the full handshake; ok clears on any timing/handshake surprise.
  task automatic run_op(input int r, input logic [3:0] x, input logic [3:0] y, input logic m,
                        output logic [3:0] s, output logic ovu, output logic ovs,
                        output logic ok);
    int n;
    ok = 1'b1;
    if (r == 0) begin x0 = x; y0 = y; mode0 = m; end
    else begin x1 = x; y1 = y; mode1 = m; end
    req_valid = 2'b00;
    req_valid[r] = 1'b1;
    res_ready = 2'b11;
    #1;
    n = 0;
    while (!REQ_READY[r] && n < 10) begin
      @(negedge CLK);
      n++;
    end
    if (n == 10) ok = 1'b0;
    @(negedge CLK);
    req_valid = 2'b00;
    if (BUSY !== 1'b1 || RES_VALID !== 2'b00) ok = 1'b0;
    @(negedge CLK);
    if (RES_VALID[r] !== 1'b1 || GRANT_ID !== r[0]) ok = 1'b0;
    s = S; ovu = OVU; ovs = OVS;
    @(negedge CLK);
    if (BUSY !== 1'b0) ok = 1'b0;
  endtask

  task automatic test_reset();
    req_valid = 2'b01;
    #1;
    checks++;
    if ({REQ_READY, RES_VALID, S, OVU, OVS, BUSY, GRANT_ID} !== 12'd0) begin
      failures++;
      $display("FAIL reset_outputs got rdy=%b rv=%b s=%0d ovu=%b ovs=%b busy=%b gid=%b want all 0",
               REQ_READY, RES_VALID, S, OVU, OVS, BUSY, GRANT_ID);
    end
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    req_valid = 2'b00;
    @(negedge CLK);
    checks++;
    if (BUSY !== 1'b0 || REQ_READY !== 2'b00) begin
      failures++;
      $display("FAIL reset_idle got busy=%b rdy=%b want 0 00", BUSY, REQ_READY);
    end
  endtask

  task automatic test_add();
    logic [3:0] s;
    logic ovu, ovs, ok;
    run_op(0, 4'd7, 4'd1, 1'b0, s, ovu, ovs, ok);
    checks++;
    if (ok !== 1'b1) begin failures++; $display("FAIL add_7_1_handshake got ok=%b want 1", ok); end
    checks++;
    if ({s, ovu, ovs} !== {4'd8, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL add_7_1 got s=%0d ovu=%b ovs=%b want s=8 ovu=0 ovs=1", s, ovu, ovs);
    end
    run_op(0, 4'd15, 4'd1, 1'b0, s, ovu, ovs, ok);
    checks++;
    if ({ok, s, ovu, ovs} !== {1'b1, 4'd0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL add_15_1 got ok=%b s=%0d ovu=%b ovs=%b want ok=1 s=0 ovu=1 ovs=0",
               ok, s, ovu, ovs);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] s;
    logic ovu, ovs, ok;
    x1 = 4'd3; y1 = 4'd5; mode1 = 1'b1;
    req_valid = 2'b10;
    #1;
    @(negedge CLK);
    req_valid = 2'b00;
    checks++;
    if (BUSY !== 1'b1 || GRANT_ID !== 1'b1) begin
      failures++;
      $display("FAIL mid_exec got busy=%b gid=%b want 1 1", BUSY, GRANT_ID);
    end
    RST = 1'b1;
    #1;
    checks++;
    if ({RES_VALID, S, OVU, OVS, BUSY, GRANT_ID} !== 10'd0) begin
      failures++;
      $display("FAIL mid_reset got rv=%b s=%0d ovu=%b ovs=%b busy=%b gid=%b want all 0",
               RES_VALID, S, OVU, OVS, BUSY, GRANT_ID);
    end
    @(negedge CLK);
    RST = 1'b0;
    req_valid = 2'b11;
    #1;
    checks++;
    if (REQ_READY !== 2'b01 || BUSY !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_tie got rdy=%b busy=%b want 01 0", REQ_READY, BUSY);
    end
    req_valid = 2'b00;
    @(negedge CLK);
    run_op(0, 4'd8, 4'd1, 1'b1, s, ovu, ovs, ok);
    checks++;
    if ({ok, s, ovu, ovs} !== {1'b1, 4'd7, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL sub_8_1_after_reset got ok=%b s=%0d ovu=%b ovs=%b want ok=1 s=7 ovu=1 ovs=1",
               ok, s, ovu, ovs);
    end
  endtask

  task automatic test_sub();
    logic [3:0] s;
    logic ovu, ovs, ok;
    run_op(1, 4'd3, 4'd5, 1'b1, s, ovu, ovs, ok);
    checks++;
    if ({ok, s, ovu, ovs} !== {1'b1, 4'd14, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL sub_3_5 got ok=%b s=%0d ovu=%b ovs=%b want ok=1 s=14 ovu=0 ovs=0",
               ok, s, ovu, ovs);
    end
    run_op(1, 4'd5, 4'd3, 1'b1, s, ovu, ovs, ok);
    checks++;
    if ({ok, s, ovu, ovs} !== {1'b1, 4'd2, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL sub_5_3 got ok=%b s=%0d ovu=%b ovs=%b want ok=1 s=2 ovu=1 ovs=0",
               ok, s, ovu, ovs);
    end
  endtask

  task automatic test_round_robin();
    int nacc, nres, last_c;
    logic [3:0] grants;
    logic interval_ok, s_ok;
    nacc = 0; nres = 0; last_c = -1; grants = 4'b0000; interval_ok = 1'b1; s_ok = 1'b1;
    x0 = 4'd2; y0 = 4'd3; mode0 = 1'b0;
    x1 = 4'd9; y1 = 4'd2; mode1 = 1'b1;
    res_ready = 2'b11;
    req_valid = 2'b11;
    #1;
    for (int c = 0; c < 12; c++) begin
      if (REQ_READY != 2'b00) begin
        if (nacc < 4) grants[nacc] = REQ_READY[1];
        if (last_c >= 0 && c - last_c != 3) interval_ok = 1'b0;
        last_c = c;
        nacc++;
      end
      if (RES_VALID != 2'b00) nres++;
      if (RES_VALID[0] && S !== 4'd5) s_ok = 1'b0;
      if (RES_VALID[1] && S !== 4'd7) s_ok = 1'b0;
      @(negedge CLK);
    end
    req_valid = 2'b00;
    checks++;
    if (nacc != 4 || grants !== 4'b1010 || !interval_ok) begin
      failures++;
      $display("FAIL rr_grants got n=%0d seq(lsb first)=%b every3=%b want n=4 seq=1010 every3=1",
               nacc, grants, interval_ok);
    end
    checks++;
    if (nres != 4 || !s_ok) begin
      failures++;
      $display("FAIL rr_results got n=%0d s_ok=%b want n=4 s_ok=1", nres, s_ok);
    end
    #1;
    checks++;
    if (BUSY !== 1'b0) begin failures++; $display("FAIL rr_drain got busy=%b want 0", BUSY); end
  endtask

  task automatic test_fixed_prio();
    int nacc, n1;
    nacc = 0; n1 = 0;
    f_res_ready = 2'b11;
    f_req_valid = 2'b11;
    #1;
    for (int c = 0; c < 12; c++) begin
      if (f_req_ready != 2'b00) begin
        nacc++;
        if (f_req_ready[1] || f_grant === 1'b1) n1++;
      end
      if (f_res_valid[1]) n1++;
      @(negedge CLK);
    end
    f_req_valid = 2'b00;
    checks++;
    if (nacc != 4 || n1 != 0) begin
      failures++;
      $display("FAIL fixed_prio got accepts=%0d grants_to_1=%0d want 4 0", nacc, n1);
    end
  endtask

  task automatic test_stall();
    x0 = 4'd4; y0 = 4'd6; mode0 = 1'b1;
    x1 = 4'd6; y1 = 4'd5; mode1 = 1'b0;
    res_ready = 2'b10;
    req_valid = 2'b01;
    #1;
    checks++;
    if (REQ_READY !== 2'b01) begin
      failures++;
      $display("FAIL stall_accept got rdy=%b want 01", REQ_READY);
    end
    @(negedge CLK);
    req_valid = 2'b10;
    #1;
    checks++;
    if (REQ_READY !== 2'b00) begin
      failures++;
      $display("FAIL stall_exec_rdy got rdy=%b want 00", REQ_READY);
    end
    @(negedge CLK);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (RES_VALID !== 2'b01 || REQ_READY !== 2'b00 || {S, OVU, OVS} !== {4'd14, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL stall_resp_%0d got rv=%b rdy=%b s=%0d ovu=%b ovs=%b want 01 00 14 0 0",
                 i, RES_VALID, REQ_READY, S, OVU, OVS);
      end
      @(negedge CLK);
    end
    res_ready = 2'b01;
    @(negedge CLK);
    #1;
    checks++;
    if (REQ_READY !== 2'b10 || BUSY !== 1'b0 || RES_VALID !== 2'b00) begin
      failures++;
      $display("FAIL stall_release got rdy=%b busy=%b rv=%b want 10 0 00",
               REQ_READY, BUSY, RES_VALID);
    end
    res_ready = 2'b11;
    @(negedge CLK);
    req_valid = 2'b00;
    @(negedge CLK);
    checks++;
    if (RES_VALID !== 2'b10 || GRANT_ID !== 1'b1 || {S, OVU, OVS} !== {4'd11, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL stall_next got rv=%b gid=%b s=%0d ovu=%b ovs=%b want 10 1 11 0 1",
               RES_VALID, GRANT_ID, S, OVU, OVS);
    end
    @(negedge CLK);
  endtask

  initial begin
    test_reset();
    test_add();
    test_reset_mid();
    test_sub();
    test_round_robin();
    test_fixed_prio();
    test_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got still running want finished");
    $fatal(1, "timeout");
  end

endmodule
